// File: rtl/dpram_block_mover_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpram_mover_pkg
// Description : Shared types and constants for the dual-port RAM block mover.
//               The state enum and mode encodings are used by the mover and
//               by anything that decodes its command interface.
// Revision    : 1.0 - initial release
// ============================================================================
package dpram_mover_pkg;

    // Mover sequencing states. The encoding is explicit so the state can be
    // probed on a debug bus without depending on tool enum ordering.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } mover_state_t;

    // Command mode encodings for the mode input.
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage : dpram_mover_pkg
`default_nettype wire

// File: rtl/dpram_block_mover_if.sv
`default_nettype none
// ============================================================================
// Module      : dpram_block_mover_if
// Description : Command and RAM-port bundle for the block mover. The master
//               modport is the mover's view; the slave modport is the view of
//               the command source together with the RAM port it drives.
// Revision    : 1.0 - initial release
// ============================================================================
interface dpram_block_mover_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    // Command side
    logic          start;
    logic          mode;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   len;
    logic [DW-1:0] fill_data;
    logic          busy;
    logic          done;

    // RAM port side
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;

    modport master (
        input  start, mode, src_addr, dst_addr, len, fill_data, ram_q,
        output busy, done, ram_addr, ram_wren, ram_data
    );

    modport slave (
        output start, mode, src_addr, dst_addr, len, fill_data, ram_q,
        input  busy, done, ram_addr, ram_wren, ram_data
    );

endinterface : dpram_block_mover_if
`default_nettype wire

// File: rtl/dpram_block_mover.sv
`default_nettype none
// ============================================================================
// Module      : dpram_block_mover
// Description : Bus master for one port of a dual-port RAM. Executes block
//               COPY (src -> dst, 2 cycles/byte) and FILL (constant -> dst,
//               1 cycle/byte). Addresses wrap modulo 2^AW independently.
//               COPY is strictly ascending, one byte at a time, so an
//               overlapping forward copy replicates the leading pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_block_mover
    import dpram_mover_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  wire logic          clock,
    input  wire logic          reset,
    dpram_block_mover_if.master bus
);

    mover_state_t  r_state;
    logic [AW-1:0] r_src;      // next source address to read
    logic [AW-1:0] r_dst;      // next destination address to write
    logic [AW:0]   r_rem;      // bytes still to be written after the current one
    logic [DW-1:0] r_fill;     // latched FILL value
    logic [DW-1:0] r_data;     // write data shown outside COPY write cycles
    logic [AW-1:0] r_addr;
    logic          r_wren;
    logic          r_busy;
    logic          r_done;

    // Command sequencing: latches the command on accept and registers every
    // RAM-port control so the port sees clean, glitch-free signals.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_fill  <= '0;
            r_data  <= '0;
            r_addr  <= '0;
            r_wren  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wren <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_fill <= bus.fill_data;
                        if (bus.len == '0) begin
                            // Empty transfer: complete without touching RAM.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (bus.mode == MODE_COPY) begin
                            // Issue the first read straight away.
                            r_state <= RD;
                            r_busy  <= 1'b1;
                            r_addr  <= bus.src_addr;
                            r_src   <= bus.src_addr + 1'b1;
                            r_dst   <= bus.dst_addr;
                            r_rem   <= bus.len;
                        end else begin
                            // Issue the first fill write straight away.
                            r_state <= FILL;
                            r_busy  <= 1'b1;
                            r_addr  <= bus.dst_addr;
                            r_wren  <= 1'b1;
                            r_data  <= bus.fill_data;
                            r_dst   <= bus.dst_addr + 1'b1;
                            r_rem   <= bus.len - 1'b1;
                        end
                    end
                end

                RD: begin
                    // Read is in flight; next cycle writes its data.
                    r_state <= WR;
                    r_addr  <= r_dst;
                    r_wren  <= 1'b1;
                    r_dst   <= r_dst + 1'b1;
                    r_rem   <= r_rem - 1'b1;
                end

                WR: begin
                    // Keep the byte just written visible once the write ends.
                    r_data <= bus.ram_q;
                    if (r_rem == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= RD;
                        r_addr  <= r_src;
                        r_src   <= r_src + 1'b1;
                    end
                end

                FILL: begin
                    if (r_rem == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr <= r_dst;
                        r_wren <= 1'b1;
                        r_dst  <= r_dst + 1'b1;
                        r_rem  <= r_rem - 1'b1;
                    end
                end

                DONE: begin
                    // Start is ignored here; a new command is taken next cycle.
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // During a COPY write the data comes straight from the RAM's own output
    // register, which is what allows a read and its write in back-to-back
    // cycles. In every other cycle the mover's held register is shown.
    assign bus.ram_data = (r_state == WR) ? bus.ram_q : r_data;
    assign bus.ram_addr = r_addr;
    assign bus.ram_wren = r_wren;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule : dpram_block_mover
`default_nettype wire
